// File: rtl/ram_pkg.sv
// Shared widths and types for the RAM command-side arbiter.
// Holds the requester ids, the command word and the read-tag format.
package ram_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 5;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } ram_cmd_t;

  typedef struct packed {
    logic    vld;
    req_id_e id;
  } rd_tag_t;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the priority pointer flips to the loser after
// every grant, so a contending requester waits at most one cycle.
module rr_arb2
  import ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  req_id_e prio_q, prio_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (prio_q == REQ_A) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt_o[0]) begin
      prio_d = other_req(REQ_A);
    end else if (gnt_o[1]) begin
      prio_d = other_req(REQ_B);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= REQ_A;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Serialises commands from requesters A and B onto a single-port RAM and
// routes each read's data back to its issuer through a two-stage tag pipe.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = ram_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_wr,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_wr,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_wr_en,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  import ram_pkg::*;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       accept;
  req_id_e    gnt_id;
  ram_cmd_t   cmd_sel;

  // Requests are masked while reset is held so ready stays low throughout.
  assign req = {b_valid, a_valid} & {2{rst}};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (req),
    .gnt_o (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];
  assign accept  = |gnt;
  assign gnt_id  = gnt[1] ? REQ_B : REQ_A;

  always_comb begin
    cmd_sel = '{wr: a_wr, addr: a_addr, wdata: a_wdata};
    if (gnt[1]) begin
      cmd_sel = '{wr: b_wr, addr: b_addr, wdata: b_wdata};
    end
  end

  // RAM command stage
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  always_comb begin
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      wr_en_d = cmd_sel.wr;
      rd_en_d = !cmd_sel.wr;
      addr_d  = cmd_sel.addr;
      if (cmd_sel.wr) begin
        wdata_d = cmd_sel.wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign ram_wr_en   = wr_en_q;
  assign ram_rd_en   = rd_en_q;
  assign ram_addr    = addr_q;
  assign ram_data_in = wdata_q;

  // Stage 1 rides with the RAM command, stage 2 with ram_data_out.
  rd_tag_t tag1_q, tag1_d;
  rd_tag_t tag2_q, tag2_d;

  always_comb begin
    tag1_d.vld = accept && !cmd_sel.wr;
    tag1_d.id  = gnt_id;
    tag2_d     = tag1_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag1_q <= '0;
      tag2_q <= '0;
    end else begin
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
    end
  end

  // Response demux
  logic                  a_rvalid_q, a_rvalid_d;
  logic                  b_rvalid_q, b_rvalid_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;

  always_comb begin
    a_rvalid_d = tag2_q.vld && (tag2_q.id == REQ_A);
    b_rvalid_d = tag2_q.vld && (tag2_q.id == REQ_B);
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    if (a_rvalid_d) begin
      a_rdata_d = ram_data_out;
    end
    if (b_rvalid_d) begin
      b_rdata_d = ram_data_out;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed and random stimulus for ram_port_arbiter, checked every cycle
// against a queue-based reference model of the arbiter and RAM behaviour.
module tb_ram_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          a_valid = 1'b0, a_wr = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          b_valid = 1'b0, b_wr = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          a_ready, b_ready, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_wr_en, ram_rd_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out = '0;

  logic [DW-1:0] ram_mem [32] = '{default: 8'h00};

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_wr         (a_wr),
    .a_addr       (a_addr),
    .a_wdata      (a_wdata),
    .a_rvalid     (a_rvalid),
    .a_rdata      (a_rdata),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_wr         (b_wr),
    .b_addr       (b_addr),
    .b_wdata      (b_wdata),
    .b_rvalid     (b_rvalid),
    .b_rdata      (b_rdata),
    .ram_wr_en    (ram_wr_en),
    .ram_rd_en    (ram_rd_en),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  // The 32x8 RAM the arbiter drives: one-cycle registered read.
  always @(posedge clk) begin
    if (ram_wr_en) ram_mem[ram_addr] <= ram_data_in;
    if (ram_rd_en) ram_data_out <= ram_mem[ram_addr];
  end

  // Reference model state
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } resp_t;

  resp_t         qa[$];
  resp_t         qb[$];
  logic [DW-1:0] ref_mem [32] = '{default: 8'h00};
  int            prio;
  logic          cmd_vld, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  int            cmd_id;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, last_a, last_b;
  logic          ga, gb;
  int            cyc = 0;
  int            tests_run = 0;
  int            tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    prio    = 0;
    cmd_vld = 1'b0;
    cmd_wr  = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    last_a  = '0;
    last_b  = '0;
    qa.delete();
    qb.delete();
  endtask

  // One clock cycle: compare everything at the falling edge, then advance the model.
  task automatic cycle();
    resp_t r;
    logic  exp_av, exp_bv;
    @(negedge clk);
    if (!rst) model_reset();
    ga = rst && a_valid && (!b_valid || prio == 0);
    gb = rst && b_valid && !ga;
    check("a_ready", a_ready, ga);
    check("b_ready", b_ready, gb);
    check("ram_wr_en", ram_wr_en, cmd_vld && cmd_wr);
    check("ram_rd_en", ram_rd_en, cmd_vld && !cmd_wr);
    check("ram_addr", ram_addr, m_addr);
    check("ram_data_in", ram_data_in, m_data);

    exp_av = (qa.size() > 0) && (qa[0].due <= cyc);
    if (exp_av) begin r = qa.pop_front(); last_a = r.data; end
    exp_bv = (qb.size() > 0) && (qb[0].due <= cyc);
    if (exp_bv) begin r = qb.pop_front(); last_b = r.data; end
    check("a_rvalid", a_rvalid, exp_av);
    check("a_rdata", a_rdata, last_a);
    check("b_rvalid", b_rvalid, exp_bv);
    check("b_rdata", b_rdata, last_b);

    // The RAM performs the current command at the end of this cycle.
    if (rst && cmd_vld) begin
      if (cmd_wr) ref_mem[cmd_addr] = cmd_data;
      else if (cmd_id == 0) qa.push_back('{due: cyc + 2, data: ref_mem[cmd_addr]});
      else qb.push_back('{due: cyc + 2, data: ref_mem[cmd_addr]});
    end

    cmd_vld = ga || gb;
    if (ga) begin
      cmd_wr = a_wr; cmd_addr = a_addr; cmd_data = a_wdata; cmd_id = 0; prio = 1;
      $display("[TB] cyc %0d grant A %s addr %0d data %02h", cyc, a_wr ? "wr" : "rd", a_addr, a_wdata);
    end else if (gb) begin
      cmd_wr = b_wr; cmd_addr = b_addr; cmd_data = b_wdata; cmd_id = 1; prio = 0;
      $display("[TB] cyc %0d grant B %s addr %0d data %02h", cyc, b_wr ? "wr" : "rd", b_addr, b_wdata);
    end
    if (cmd_vld) begin
      m_addr = cmd_addr;
      if (cmd_wr) m_data = cmd_data;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_a(input logic v, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] d);
    a_valid = v; a_wr = wr; a_addr = addr; a_wdata = d;
  endtask

  task automatic set_b(input logic v, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] d);
    b_valid = v; b_wr = wr; b_addr = addr; b_wdata = d;
  endtask

  initial begin
    model_reset();
    // Reset held three cycles with both valids high
    rst = 1'b0;
    set_a(1'b1, 1'b0, 5'd0, 8'h00);
    set_b(1'b1, 1'b0, 5'd0, 8'h00);
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    set_a(1'b0, 1'b0, 5'd0, 8'h00);
    set_b(1'b0, 1'b0, 5'd0, 8'h00);
    repeat (4) cycle();

    // Single requester write then read
    set_a(1'b1, 1'b1, 5'd5, 8'hA5); cycle();
    set_a(1'b1, 1'b0, 5'd5, 8'h00); cycle();
    set_a(1'b0, 1'b0, 5'd0, 8'h00);
    repeat (5) cycle();

    // Contention: preload, then four cycles of simultaneous reads
    set_a(1'b1, 1'b1, 5'd1, 8'h11); cycle();
    set_a(1'b0, 1'b0, 5'd0, 8'h00);
    set_b(1'b1, 1'b1, 5'd2, 8'h22); cycle();
    set_a(1'b1, 1'b0, 5'd1, 8'h00);
    set_b(1'b1, 1'b0, 5'd2, 8'h00);
    repeat (4) cycle();
    set_a(1'b0, 1'b0, 5'd0, 8'h00);
    set_b(1'b0, 1'b0, 5'd0, 8'h00);
    repeat (5) cycle();

    // Write-then-read hazard on address 31
    set_b(1'b1, 1'b1, 5'd31, 8'h3C); cycle();
    set_b(1'b0, 1'b0, 5'd0, 8'h00);
    set_a(1'b1, 1'b0, 5'd31, 8'h00); cycle();
    set_a(1'b0, 1'b0, 5'd0, 8'h00);
    repeat (5) cycle();

    // Back-to-back reads from B after preloading addresses 0..7
    for (int i = 0; i < 8; i++) begin
      set_a(1'b1, 1'b1, AW'(i), DW'(8'h60 + 8'(i * 7)));
      cycle();
    end
    set_a(1'b0, 1'b0, 5'd0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      set_b(1'b1, 1'b0, AW'(i), 8'h00);
      cycle();
    end
    set_b(1'b0, 1'b0, 5'd0, 8'h00);
    repeat (5) cycle();

    // Reset one cycle after an A read handshake
    set_a(1'b1, 1'b0, 5'd5, 8'h00); cycle();
    set_a(1'b0, 1'b0, 5'd0, 8'h00);
    rst = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
    repeat (5) cycle();
    set_a(1'b1, 1'b0, 5'd1, 8'h00);
    set_b(1'b1, 1'b0, 5'd2, 8'h00);
    repeat (2) cycle();
    set_a(1'b0, 1'b0, 5'd0, 8'h00);
    set_b(1'b0, 1'b0, 5'd0, 8'h00);
    repeat (5) cycle();

    // Random traffic; a pending command is held until it is accepted
    ga = 1'b0;
    gb = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!a_valid || ga)
        set_a($urandom_range(0, 99) < 60, 1'($urandom), AW'($urandom), DW'($urandom));
      if (!b_valid || gb)
        set_b($urandom_range(0, 99) < 60, 1'($urandom), AW'($urandom), DW'($urandom));
      cycle();
    end
    set_a(1'b0, 1'b0, 5'd0, 8'h00);
    set_b(1'b0, 1'b0, 5'd0, 8'h00);
    repeat (6) cycle();
    check("a_queue_drained", 32'(qa.size()), 32'd0);
    check("b_queue_drained", 32'(qb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
